seg_trace_decoder: RTL

Observer block for the microprocessor board outputs: it samples the six 7-segment digit buses and the LED, decodes them back to binary, and applies a stability filter so combinational glitches are ignored. Each stable display state that differs from the previous one becomes a trace record in a small FIFO. A valid/ready port drains the FIFO, so benches and on-board capture logic can read the processor's address, instruction and result sequence without parsing segment patterns.

---
 rtl/seg_trace_decoder_if.sv | 15 +
 rtl/seg_trace_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_trace_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_trace_decoder_if
// Purpose  : Valid/ready trace-record port of seg_trace_decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_trace_decoder_if;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface
`default_nettype wire

// File: rtl/seg_trace_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_trace_decoder
// Purpose  : Decodes the six 7-segment buses and LED into stability-filtered
//            trace records, queued in a FIFO drained over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module seg_trace_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [6:0]          AddressTens,
    input  logic [6:0]          AddressOnes,
    input  logic [6:0]          InstTens,
    input  logic [6:0]          InstOnes,
    input  logic [6:0]          Tens,
    input  logic [6:0]          Ones,
    input  logic                LED,
    seg_trace_decoder_if.master trace,
    output logic                overflow,
    output logic [7:0]          drop_count
);
    localparam int         c_AW     = $clog2(DEPTH);
    localparam logic [8:0] c_STABLE = 9'(STABLE_CYCLES);

    localparam logic [1:0] c_WAIT   = 2'd0;
    localparam logic [1:0] c_COUNT  = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    logic [42:0] w_bus;
    logic [42:0] r_sample;
    logic        r_sample_vld;
    logic        w_same;

    assign w_bus = {AddressTens, AddressOnes, InstTens, InstOnes, Tens, Ones, LED};

    // The candidate always equals the last sample (it follows in WAIT, and any
    // difference reloads it), so the sample register serves as the candidate.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample     <= w_bus;
            r_sample_vld <= 1'b1;
        end
    end

    assign w_same = r_sample_vld && (w_bus == r_sample);

    logic [23:0] w_dval;
    logic [5:0]  w_dbad;

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        logic [6:0] w_seg;
        logic [3:0] w_val;
        logic       w_bad;

        assign w_seg = r_sample[7*gi+1 +: 7];

        always_comb begin
            w_val = 4'd0;
            w_bad = 1'b0;
            case (w_seg)
                7'b0000001: w_val = 4'd0;
                7'b1001111: w_val = 4'd1;
                7'b0010010: w_val = 4'd2;
                7'b0000110: w_val = 4'd3;
                7'b1001100: w_val = 4'd4;
                7'b0100100: w_val = 4'd5;
                7'b0100000: w_val = 4'd6;
                7'b0001111: w_val = 4'd7;
                7'b0000000: w_val = 4'd8;
                7'b0000100: w_val = 4'd9;
                7'b1111111: w_val = 4'd0;
                default:    w_bad = 1'b1;
            endcase
        end

        assign w_dval[4*gi +: 4] = w_val;
        assign w_dbad[gi]        = w_bad;
    end

    logic [6:0]  w_addr;
    logic [6:0]  w_inst;
    logic [6:0]  w_res;
    logic [22:0] w_rec;

    assign w_addr = 7'(w_dval[23:20]) * 7'd10 + 7'(w_dval[19:16]);
    assign w_inst = 7'(w_dval[15:12]) * 7'd10 + 7'(w_dval[11:8]);
    assign w_res  = 7'(w_dval[7:4])   * 7'd10 + 7'(w_dval[3:0]);
    assign w_rec  = {w_addr, w_inst, w_res, r_sample[0], |w_dbad};

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [8:0] w_cnt_inc;
    logic       w_commit;

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= c_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The commit fires on the edge that enters COMMIT, so the record lands on
    // the STABLE_CYCLES-th equal sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            c_WAIT, c_COUNT: begin
                if (!w_same) begin
                    w_state_nxt = c_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == c_STABLE) begin
                    w_state_nxt = c_COMMIT;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = c_COUNT;
                    w_cnt_nxt   = w_cnt_inc[7:0];
                end
            end
            default: begin
                if (!w_same) begin
                    w_state_nxt = c_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = c_HOLD;
                end
            end
        endcase
    end

    logic [22:0] r_last;
    logic        r_last_vld;
    logic        w_push;

    assign w_push = w_commit && (!r_last_vld || (w_rec != r_last));

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_commit) begin
            r_last     <= w_rec;
            r_last_vld <= 1'b1;
        end
    end

    logic [c_AW:0] r_wr;
    logic [c_AW:0] r_rd;
    logic [22:0]   r_mem [DEPTH];
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop   = !w_empty && trace.out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[c_AW-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr <= r_wr + {{c_AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd <= r_rd + {{c_AW{1'b0}}, 1'b1};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    assign trace.out_valid = !w_empty;
    assign trace.out_data  = w_empty ? '0 : r_mem[r_rd[c_AW-1:0]];
    assign overflow        = r_overflow;
    assign drop_count      = r_drop_count;
endmodule
`default_nettype wire
